board_writer: RTL

//  Write side of the 9-cell tic-tac-toe board; the 9-to-1 cell read mux is the read side.

---
 rtl/tictac_pkg.sv | 23 ++
 rtl/board_writer.sv | 119 +++++++++++
 2 files changed

// File: rtl/tictac_pkg.sv
// tictac_pkg: cell codes, response codes, board size and FSM encoding shared by writer and read mux
package tictac_pkg;

    localparam int NUM_CELLS = 9;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] PX    = 2'd1;
    localparam logic [1:0] PO    = 2'd2;

    localparam logic [2:0] OK       = 3'd0;
    localparam logic [2:0] RANGE    = 3'd1;
    localparam logic [2:0] OCCUPIED = 3'd2;
    localparam logic [2:0] PLAYER   = 3'd3;
    localparam logic [2:0] TURN     = 3'd4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    function automatic logic [1:0] other(input logic [1:0] p);
        return p == PX ? PO : PX;
    endfunction

endpackage

// File: rtl/board_writer.sv
// board_writer: validates and writes tic-tac-toe moves, tracks turn/count, sequences board clear
module board_writer
    import tictac_pkg::*;
#(
    parameter int CELL_W    = 16,
    parameter int NUM_CELLS = tictac_pkg::NUM_CELLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move_valid,
    output logic              move_ready,
    input  logic [3:0]        move_sel,
    input  logic [1:0]        move_player,
    input  logic              clear_req,
    output logic              resp_valid,
    output logic              resp_ok,
    output logic [2:0]        resp_code,
    output logic [CELL_W-1:0] cell1,
    output logic [CELL_W-1:0] cell2,
    output logic [CELL_W-1:0] cell3,
    output logic [CELL_W-1:0] cell4,
    output logic [CELL_W-1:0] cell5,
    output logic [CELL_W-1:0] cell6,
    output logic [CELL_W-1:0] cell7,
    output logic [CELL_W-1:0] cell8,
    output logic [CELL_W-1:0] cell9,
    output logic [3:0]        move_count,
    output logic [1:0]        turn,
    output logic              board_full,
    output logic              clearing
);

    localparam logic [3:0] LAST = 4'(NUM_CELLS - 1);

    logic [1:0] cells [NUM_CELLS];
    logic [0:0] state;
    logic [3:0] idx;
    logic [1:0] target;
    logic [2:0] code;
    logic       take;
    logic       legal;
    logic       clr_done;

    assign move_ready = state == IDLE && !clear_req;
    assign take       = move_valid && move_ready;
    assign legal      = take && code == OK;
    assign clearing   = state == CLEAR;
    assign clr_done   = clearing && idx == LAST;
    assign board_full = move_count == 4'(NUM_CELLS);

    assign cell1 = CELL_W'(cells[0]);
    assign cell2 = CELL_W'(cells[1]);
    assign cell3 = CELL_W'(cells[2]);
    assign cell4 = CELL_W'(cells[3]);
    assign cell5 = CELL_W'(cells[4]);
    assign cell6 = CELL_W'(cells[5]);
    assign cell7 = CELL_W'(cells[6]);
    assign cell8 = CELL_W'(cells[7]);
    assign cell9 = CELL_W'(cells[8]);

    // legality check: the first failing rule decides the code; the cell is only looked up when in range
    always_comb begin
        target = move_sel > LAST ? EMPTY : cells[move_sel];
        code   = move_sel > LAST                       ? RANGE    :
                 move_player != PX && move_player != PO ? PLAYER   :
                 move_player != turn                    ? TURN     :
                 target != EMPTY                        ? OCCUPIED : OK;
    end

    // cell array: legal moves write the addressed cell, the clear sequence zeroes one cell per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CELLS; i++) cells[i] <= EMPTY;
        end else if (clearing) begin
            cells[idx] <= EMPTY;
        end else if (legal) begin
            cells[move_sel] <= move_player;
        end
    end

    // FSM and clear index: clear_req in IDLE starts a 9-cycle sweep, ignored while sweeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else if (state == IDLE) begin
            state <= clear_req ? CLEAR : IDLE;
            idx   <= '0;
        end else begin
            state <= clr_done ? IDLE : CLEAR;
            idx   <= clr_done ? idx : idx + 4'd1;
        end
    end

    // game progress: count saturates at a full board, turn alternates on each legal move
    always_ff @(posedge clk) begin
        if (rst || clr_done) begin
            move_count <= '0;
            turn       <= PX;
        end else if (legal) begin
            move_count <= board_full ? move_count : move_count + 4'd1;
            turn       <= other(turn);
        end
    end

    // response: pulse valid for every taken move, ok/code hold until the next taken move
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            resp_code  <= OK;
        end else begin
            resp_valid <= take;
            resp_ok    <= take ? code == OK : resp_ok;
            resp_code  <= take ? code : resp_code;
        end
    end

endmodule
